// File: rtl/timer_share_arbiter_if.sv
// Client-side bundle for the shared interval timer.
// The master side is the set of requesters; the slave side is the arbiter.
interface timer_share_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] len;
    logic [3:0]         grant;
    logic [3:0]         done;
    logic               busy;
    logic [WIDTH-1:0]   cnt;

    modport master (
        output req,
        output len,
        input  grant,
        input  done,
        input  busy,
        input  cnt
    );

    modport slave (
        input  req,
        input  len,
        output grant,
        output done,
        output busy,
        output cnt
    );
endinterface

// File: rtl/timer_share_arbiter.sv
// Round-robin owner of one shared up counter, serving four interval requesters.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | counter parked at 0, arbitrate among pending requests
//   RUN   | counter owned by r_grant, counting prescaled ticks to r_term
//   DONE  | one-cycle done pulse to the owner, grant still held
module timer_share_arbiter #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  n_reset,
    timer_share_arbiter_if.slave  bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_grant;
    logic [3:0]       r_done;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_term;
    logic [PW-1:0]    r_presc;
    logic [1:0]       r_last;

    state_t           w_nxt_state;
    logic [3:0]       w_nxt_grant;
    logic [3:0]       w_nxt_done;
    logic [WIDTH-1:0] w_nxt_cnt;
    logic [WIDTH-1:0] w_nxt_term;
    logic [PW-1:0]    w_nxt_presc;
    logic [1:0]       w_nxt_last;

    logic [1:0]       w_winner;
    logic [1:0]       w_cand;
    logic             w_found;
    logic             w_tick;
    logic             w_owner_req;

    assign w_tick      = (r_presc == PW'(PRESCALE - 1));
    assign w_owner_req = |(bus.req & r_grant);

    // Search upward from the last winner so the last-served requester ranks lowest.
    always_comb begin
        w_winner = r_last;
        w_cand   = r_last;
        w_found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            w_cand = r_last + 2'(i);
            if (!w_found && bus.req[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; abort is checked ahead of the terminal tick.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_done  = '0;
        w_nxt_cnt   = r_cnt;
        w_nxt_term  = r_term;
        w_nxt_presc = r_presc;
        w_nxt_last  = r_last;
        case (r_state)
            ST_IDLE: begin
                w_nxt_grant = '0;
                w_nxt_cnt   = '0;
                if (w_found) begin
                    w_nxt_state = ST_RUN;
                    w_nxt_grant = 4'b0001 << w_winner;
                    w_nxt_term  = bus.len[int'(w_winner)*WIDTH +: WIDTH];
                    w_nxt_presc = '0;
                    w_nxt_last  = w_winner;
                end
            end
            ST_RUN: begin
                if (!w_owner_req) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_grant = '0;
                    w_nxt_cnt   = '0;
                    w_nxt_presc = '0;
                end else if (w_tick) begin
                    w_nxt_presc = '0;
                    if (r_cnt == r_term) begin
                        w_nxt_state = ST_DONE;
                        w_nxt_done  = r_grant;
                    end else begin
                        w_nxt_cnt = r_cnt + WIDTH'(1);
                    end
                end else begin
                    w_nxt_presc = r_presc + PW'(1);
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
                w_nxt_grant = '0;
                w_nxt_cnt   = '0;
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_grant = '0;
                w_nxt_cnt   = '0;
                w_nxt_presc = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_cnt   <= '0;
            r_term  <= '0;
            r_presc <= '0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_done  <= w_nxt_done;
            r_cnt   <= w_nxt_cnt;
            r_term  <= w_nxt_term;
            r_presc <= w_nxt_presc;
            r_last  <= w_nxt_last;
        end
    end

    assign bus.grant = r_grant;
    assign bus.done  = r_done;
    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.cnt   = r_cnt;

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Scoreboard bench: two arbiters (PRESCALE 1 and 3) share clock and reset.
module tb_timer_share_arbiter;

    logic clk;
    logic n_reset;

    timer_share_arbiter_if #(.WIDTH(4)) bus_p1 ();
    timer_share_arbiter_if #(.WIDTH(4)) bus_p3 ();

    timer_share_arbiter #(.WIDTH(4), .PRESCALE(1)) u_dut_p1 (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus_p1.slave)
    );

    timer_share_arbiter #(.WIDTH(4), .PRESCALE(3)) u_dut_p3 (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus_p3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        logic [3:0] grant;
        logic [3:0] done;
        logic       busy;
        logic [3:0] cnt;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [3:0] g, input logic [3:0] dn,
                        input logic b, input logic [3:0] c, input string t);
        exp_t e;
        e.dut = d; e.grant = g; e.done = dn; e.busy = b; e.cnt = c; e.tag = t;
        sb.push_back(e);
    endtask

    // Advance one cycle, then compare one scoreboard entry against the selected DUT.
    task automatic step();
        exp_t       e;
        logic [3:0] g, dn, c;
        logic       b;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                g = bus_p1.grant; dn = bus_p1.done; b = bus_p1.busy; c = bus_p1.cnt;
            end else begin
                g = bus_p3.grant; dn = bus_p3.done; b = bus_p3.busy; c = bus_p3.cnt;
            end
            chk({e.tag, ".grant"}, 32'(g),  32'(e.grant));
            chk({e.tag, ".done"},  32'(dn), 32'(e.done));
            chk({e.tag, ".busy"},  32'(b),  32'(e.busy));
            chk({e.tag, ".cnt"},   32'(c),  32'(e.cnt));
        end
    endtask

    // One full service of requester w: (L+1)*P run cycles, a done cycle, an idle cycle.
    task automatic serve(input int d, input int w, input int L, input int P,
                         input bit drop, input string t);
        logic [3:0] g;
        int         nrun;
        g    = 4'b0001 << w;
        nrun = (L + 1) * P;
        for (int j = 0; j < nrun; j++) push(d, g, 4'b0, 1'b1, 4'(j / P), {t, "_run"});
        push(d, g, g, 1'b1, 4'(L), {t, "_done"});
        push(d, 4'b0, 4'b0, 1'b0, 4'b0, {t, "_idle"});
        for (int j = 0; j < nrun + 2; j++) begin
            step();
            if (j == nrun && drop) begin
                if (d == 0) bus_p1.req[w] = 1'b0;
                else        bus_p3.req[w] = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input string t);
        n_reset = 1'b0;
        push(0, 4'b0, 4'b0, 1'b0, 4'b0, {t, "_p1"});
        step();
        push(1, 4'b0, 4'b0, 1'b0, 4'b0, {t, "_p3"});
        step();
        n_reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_reset    = 1'b0;
        bus_p1.req = '0;
        bus_p1.len = '0;
        bus_p3.req = '0;
        bus_p3.len = '0;
        do_reset("reset");

        // single request, L=3
        bus_p1.len[3:0] = 4'd3;
        bus_p1.req      = 4'b0001;
        serve(0, 0, 3, 1, 1'b1, "single");

        // round robin with all requests held, all lengths 1
        do_reset("rr_reset");
        bus_p1.len = {4'd1, 4'd1, 4'd1, 4'd1};
        bus_p1.req = 4'b1111;
        serve(0, 0, 1, 1, 1'b0, "rr0");
        serve(0, 1, 1, 1, 1'b0, "rr1");
        serve(0, 2, 1, 1, 1'b0, "rr2");
        serve(0, 3, 1, 1, 1'b0, "rr3");
        serve(0, 0, 1, 1, 1'b0, "rr0b");
        bus_p1.req = 4'b0000;
        push(0, 4'b0, 4'b0, 1'b0, 4'b0, "rr_quiet");
        step();

        // abort after three granted cycles
        bus_p1.len[11:8] = 4'd10;
        bus_p1.req       = 4'b0100;
        for (int j = 0; j < 3; j++) push(0, 4'b0100, 4'b0, 1'b1, 4'(j), "abort_run");
        for (int j = 0; j < 3; j++) step();
        bus_p1.req = 4'b0000;
        push(0, 4'b0, 4'b0, 1'b0, 4'b0, "abort_idle");
        push(0, 4'b0, 4'b0, 1'b0, 4'b0, "abort_idle2");
        step();
        step();

        // length boundaries
        bus_p1.len[3:0] = 4'd0;
        bus_p1.req      = 4'b0001;
        serve(0, 0, 0, 1, 1'b1, "len0");
        bus_p1.len[3:0] = 4'd15;
        bus_p1.req      = 4'b0001;
        serve(0, 0, 15, 1, 1'b1, "len15");

        // reset in RUN with cnt=5, req still held; then pointer must favour requester 0
        bus_p1.len[7:4] = 4'd9;
        bus_p1.req      = 4'b0010;
        for (int j = 0; j < 6; j++) push(0, 4'b0010, 4'b0, 1'b1, 4'(j), "midrst_run");
        for (int j = 0; j < 6; j++) step();
        n_reset = 1'b0;
        push(0, 4'b0, 4'b0, 1'b0, 4'b0, "midrst_clear");
        step();
        n_reset    = 1'b1;
        bus_p1.len = {4'd1, 4'd0, 4'd0, 4'd1};
        bus_p1.req = 4'b1001;
        serve(0, 0, 1, 1, 1'b1, "post_rst_r0");
        serve(0, 3, 1, 1, 1'b1, "post_rst_r3");

        // prescale 3, L=2
        bus_p3.len[3:0] = 4'd2;
        bus_p3.req      = 4'b0001;
        serve(1, 0, 2, 3, 1'b1, "presc3");

        if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_share_arbiter.md
# timer_share_arbiter

Round-robin scheduler that shares a single 4-bit up counter between four requesters that each need a timed interval. Each requester raises a request with a length. The block grants one requester at a time, clears and runs the shared counter up to that length, then pulses done to the winner. It sits between the counter datapath and the client blocks that need delays, so clients never drive the counter directly.

## Interface
- WIDTH, 4: counter and length width in bits.
- PRESCALE, 1: clocks per counter tick; must be ≥1.
- clk  in  1  system clock; all state updates on its rising edge.
- n_reset  in  1  synchronous, active-low reset.
- req  in  4  request vector; req[i] is held high by requester i until its done pulse or until it aborts.
- len  in  4*WIDTH  packed lengths; requester i uses len[WIDTH*i+WIDTH-1 : WIDTH*i], sampled only at grant.
- grant  out  4  one-hot, registered; the current owner of the counter.
- done  out  4  one-cycle pulse, registered; the interval for that requester has completed.
- busy  out  1  high whenever the state is not IDLE.
- cnt  out  WIDTH  current value of the shared counter.

## Operation
- States: IDLE, RUN, DONE.
- Reset (n_reset=0 at a clk edge) puts the block in this condition:
  - state=IDLE, all of grant, done, busy and cnt = 0;
  - prescaler = 0, term = 0;
  - last-granted pointer = 3, so requester 0 has first priority.
- IDLE:
  - cnt is held at 0.
  - If req≠0, the winner is the first set bit searching upward (modulo 4) from last+1.
  - On that edge: grant is set to the winner's one-hot, term latches the winner's len, cnt=0, prescaler=0, last=winner, next state RUN.
- RUN:
  - A tick occurs when prescaler == PRESCALE-1; the prescaler then wraps to 0, otherwise it increments. With PRESCALE=1, every cycle is a tick.
  - On a tick: if cnt==term, go to DONE with cnt held; otherwise cnt increments by 1.
  - cnt never wraps, because term ≤ 2^WIDTH-1 and the compare happens before the increment.
- Abort:
  - If req[owner] is 0 in RUN, the next state is IDLE.
  - grant and cnt clear to 0, and no done pulse is issued.
  - Abort takes precedence over a same-cycle terminal tick.
- DONE:
  - done is the one-hot of the owner for exactly one cycle, and grant stays asserted.
  - Next state is IDLE, where grant clears.
  - The requester is expected to drop req in the done cycle. If req is still high in IDLE, it is treated as a new request.
- len=0: RUN lasts one tick, then DONE.
- Changes to len or to other req bits while busy have no effect on the current interval.
- Fairness: after requester i is served, requester i has the lowest priority in the next arbitration.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Let edge k be the IDLE edge that sees req. Then:
  - grant and busy are high from cycle k+1;
  - RUN lasts (L+1)·PRESCALE cycles;
  - done is high in cycle k+1+(L+1)·PRESCALE;
  - IDLE follows in the next cycle.
- The next arbitration happens at the end of that IDLE cycle. There is one idle bubble between grants, so back-to-back service costs (L+1)·PRESCALE+2 cycles.
- Example with PRESCALE=1, L=3:
  - grant is high in cycles 1–5;
  - cnt reads 0,1,2,3 in cycles 1–4;
  - done is high in cycle 5.
- Reset mid-RUN or mid-DONE:
  - the next cycle shows IDLE with all outputs 0 and no done pulse;
  - last returns to 3.

## Test plan
- Single request, PRESCALE=1: req=0001, len0=3 → grant=0001 for 5 cycles, cnt runs 0→3, done=0001 for one cycle in the 5th granted cycle, then grant=0, busy=0.
- Round-robin: req=1111 held with all lengths 1 → grant order 0001, 0010, 0100, 1000, 0001, with done pulses matching each grant and a period of 4 cycles.
- Abort: req=0100, len2=10, req[2] dropped after 3 granted cycles → the next cycle shows grant=0, cnt=0, busy=0, and done stays 0 throughout.
- Boundaries: len=0 gives done in the 2nd granted cycle. len=15 gives cnt reaching 15 with no wrap, and done after 16 granted cycles.
- Prescale: PRESCALE=3, len=2 → cnt is 0,0,0,1,1,1,2,2,2 over 9 RUN cycles, and done appears in the 10th granted cycle.
- Reset mid-operation: assert n_reset=0 during RUN with cnt=5 → the next cycle has grant=0, done=0, cnt=0, busy=0. A subsequent req=1001 is granted to requester 0 first.
